// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction fetch, data) to one-slave memory arbiter.
// Latency: request seen in IDLE at edge N is granted at N+1 and can complete there (2 cycles).
// Backpressure: masters hold requests while their wait is high; memory stalls via mready.
//
// Ports:
//   clk, rst                              clock and synchronous active-high reset
//   ireq/iaddr -> iwait/irdata            instruction-fetch master (read only)
//   dreq/dwe/daddr/dwdata/dstrb/dlock     data master; dlock keeps the grant for the next access
//   dwait/drdata                          data master stall and read data
//   mren/mwen/maddr/mwdata/mstrb          memory request, driven only while a master is granted
//   mrdata/mready                         memory read data and completion
module mem_arbiter #(
    parameter int LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] irdata,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dstrb,
    input  logic        dlock,
    output logic        dwait,
    output logic [31:0] drdata,
    output logic        mren,
    output logic        mwen,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mstrb,
    input  logic [31:0] mrdata,
    input  logic        mready
);

    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;        // last master served: 0 = fetch, 1 = data
    logic [LCW-1:0] lockcnt_q, lockcnt_d;  // locked completions already taken in this run

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;             // first conflict after reset goes to fetch
            lockcnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            lockcnt_q <= lockcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        lockcnt_d = lockcnt_q;
        case (state_q)
            IDLE: begin
                if (ireq && dreq) begin
                    // Round-robin: serve whichever master was not served last
                    state_d = last_q ? IGNT : DGNT;
                end else if (dreq) begin
                    state_d = DGNT;
                end else if (ireq) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                if (!ireq) begin
                    state_d = IDLE;
                end else if (mready) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            DGNT: begin
                if (!dreq) begin
                    // Master abandoned its request; give the port back
                    state_d   = IDLE;
                    lockcnt_d = '0;
                end else if (mready) begin
                    last_d = 1'b1;
                    // Stay granted for a locked sequence, but never more than
                    // LOCK_MAX completions in a row so fetch cannot starve.
                    if (dlock && (lockcnt_q < LCW'(LOCK_MAX - 1))) begin
                        lockcnt_d = lockcnt_q + LCW'(1);
                    end else begin
                        state_d   = IDLE;
                        lockcnt_d = '0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                lockcnt_d = '0;
            end
        endcase
    end

    // Output logic. Reset gates everything combinationally so an in-flight
    // access is abandoned in the same cycle rst rises.
    always_comb begin
        mren   = 1'b0;
        mwen   = 1'b0;
        maddr  = '0;
        mwdata = '0;
        mstrb  = '0;
        irdata = '0;
        drdata = '0;
        iwait  = ireq;
        dwait  = dreq;
        if (!rst) begin
            case (state_q)
                IGNT: begin
                    mren   = ireq;
                    maddr  = iaddr;
                    irdata = mrdata;
                    iwait  = ireq & ~mready;
                end
                DGNT: begin
                    mren   = dreq & ~dwe;
                    mwen   = dreq & dwe;
                    maddr  = daddr;
                    mwdata = dwdata;
                    mstrb  = dstrb;
                    drdata = mrdata;
                    dwait  = dreq & ~mready;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Table vectors for reset/write/wait/abort, hand sequences for round-robin and
// locking, then randomized masters checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ireq, dreq, dwe, dlock, mready;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [3:0]  dstrb;
    logic        iwait, dwait, mren, mwen;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic [3:0]  mstrb;

    mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .ireq(ireq), .iaddr(iaddr), .iwait(iwait), .irdata(irdata),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb),
        .dlock(dlock), .dwait(dwait), .drdata(drdata),
        .mren(mren), .mwen(mwen), .maddr(maddr), .mwdata(mwdata), .mstrb(mstrb),
        .mrdata(mrdata), .mready(mready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    // Tracks who owns the memory port, who was served last and how many
    // locked data completions have happened in the current run.
    typedef enum int {OWN_NONE, OWN_I, OWN_D} own_t;
    own_t owner  = OWN_NONE;
    bit   last_d = 1'b1;
    int   run    = 0;
    bit   i_done, d_done;

    function automatic logic [135:0] dut_vec();
        return {mren, mwen, iwait, dwait, maddr, mwdata, mstrb, irdata, drdata};
    endfunction

    function automatic logic [135:0] model_vec();
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_a, e_wd, e_ir, e_dr;
        logic [3:0]  e_st;
        e_ren = 0; e_wen = 0; e_a = 0; e_wd = 0; e_st = 0; e_ir = 0; e_dr = 0;
        e_iw = ireq;
        e_dw = dreq;
        if (!rst && owner == OWN_I) begin
            e_ren = ireq; e_a = iaddr; e_ir = mrdata; e_iw = ireq && !mready;
        end else if (!rst && owner == OWN_D) begin
            e_ren = dreq && !dwe; e_wen = dreq && dwe; e_a = daddr; e_wd = dwdata;
            e_st = dstrb; e_dr = mrdata; e_dw = dreq && !mready;
        end
        return {e_ren, e_wen, e_iw, e_dw, e_a, e_wd, e_st, e_ir, e_dr};
    endfunction

    task automatic model_update();
        if (rst) begin
            owner = OWN_NONE; last_d = 1'b1; run = 0;
        end else begin
            case (owner)
                OWN_NONE: begin
                    if (ireq && dreq) owner = last_d ? OWN_I : OWN_D;
                    else if (dreq)    owner = OWN_D;
                    else if (ireq)    owner = OWN_I;
                end
                OWN_I: begin
                    if (!ireq) owner = OWN_NONE;
                    else if (mready) begin
                        last_d = 1'b0; owner = OWN_NONE;
                    end
                end
                default: begin
                    if (!dreq) begin
                        owner = OWN_NONE; run = 0;
                    end else if (mready) begin
                        last_d = 1'b1;
                        run++;
                        if (!dlock || run >= LOCK_MAX) begin
                            owner = OWN_NONE; run = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic byte grant_ch();
        if (mwen) return "W";
        if (mren) return (maddr == iaddr) ? "I" : "R";
        return "-";
    endfunction

    // One clock: check against model mid-cycle, then advance model at the edge.
    task automatic do_cycle(input string tag, output byte g);
        @(negedge clk);
        check({tag, " model"}, dut_vec(), model_vec());
        g      = grant_ch();
        i_done = ireq && !iwait;
        d_done = dreq && !dwait;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; ireq = 0; dreq = 0; dwe = 0; dlock = 0; mready = 1;
        iaddr = 32'h100; daddr = 32'h3000; dwdata = 32'hBEEFBEEF; dstrb = 4'hF;
        mrdata = 32'h13;
    endtask

    task automatic apply_reset();
        byte g;
        idle_inputs();
        rst = 1;
        do_cycle("rst", g);
        do_cycle("rst", g);
        rst = 0;
    endtask

    task automatic run_seq(input string name, input string exp, input int mode);
        byte g;
        for (int i = 0; i < exp.len(); i++) begin
            if (mode == 1 && i == 4) begin dwe = 1; dlock = 0; end
            if (mode == 2 && i == 1) ireq = 1;
            do_cycle(name, g);
            check($sformatf("%s grant[%0d]", name, i), 136'(g), 136'(exp.getc(i)));
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        rst, ireq, dreq, dwe, mready;
        logic [3:0]  e_ctl;          // {mren, mwen, iwait, dwait}
        logic [31:0] e_maddr, e_mwdata;
        logic [3:0]  e_mstrb;
        logic [31:0] e_irdata, e_drdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic r, logic i, logic d, logic w, logic m, logic [3:0] c,
                                 logic [31:0] a, logic [31:0] wd, logic [3:0] st,
                                 logic [31:0] ir, logic [31:0] dr);
        vec_t v;
        v.rst = r; v.ireq = i; v.dreq = d; v.dwe = w; v.mready = m; v.e_ctl = c;
        v.e_maddr = a; v.e_mwdata = wd; v.e_mstrb = st; v.e_irdata = ir; v.e_drdata = dr;
        return v;
    endfunction

    initial begin
        byte g;
        idle_inputs();
        daddr = 32'h2000;

        // reset with pending fetch, fetch grant, data write, wait states, reset abort
        for (int i = 0; i < 3; i++) vecs.push_back(mkv(1,1,0,0,1, 4'b0010, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,1,0,0,1, 4'b0010, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,1,0,0,1, 4'b1000, 32'h100, 0, 0, 32'h13, 0));
        vecs.push_back(mkv(0,0,1,1,1, 4'b0001, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,0,1,1,1, 4'b0100, 32'h2000, 32'hBEEFBEEF, 4'hF, 0, 32'h13));
        vecs.push_back(mkv(0,0,1,0,0, 4'b0001, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkv(0,0,1,0,0, 4'b1001, 32'h2000, 32'hBEEFBEEF, 4'hF, 0, 32'h13));
        vecs.push_back(mkv(0,0,1,0,1, 4'b1000, 32'h2000, 32'hBEEFBEEF, 4'hF, 0, 32'h13));
        vecs.push_back(mkv(0,0,0,0,1, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,0,1,1,0, 4'b0001, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,0,1,1,0, 4'b0101, 32'h2000, 32'hBEEFBEEF, 4'hF, 0, 32'h13));
        vecs.push_back(mkv(1,0,1,1,0, 4'b0001, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,0,1,1,0, 4'b0001, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,0,1,1,0, 4'b0101, 32'h2000, 32'hBEEFBEEF, 4'hF, 0, 32'h13));
        vecs.push_back(mkv(0,0,1,1,1, 4'b0100, 32'h2000, 32'hBEEFBEEF, 4'hF, 0, 32'h13));
        vecs.push_back(mkv(0,0,0,0,1, 4'b0000, 0, 0, 0, 0, 0));

        #1;
        foreach (vecs[k]) begin
            rst = vecs[k].rst; ireq = vecs[k].ireq; dreq = vecs[k].dreq;
            dwe = vecs[k].dwe; mready = vecs[k].mready;
            #1;
            check($sformatf("vec%0d ctl", k),    136'({mren, mwen, iwait, dwait}), 136'(vecs[k].e_ctl));
            check($sformatf("vec%0d maddr", k),  136'(maddr),  136'(vecs[k].e_maddr));
            check($sformatf("vec%0d mwdata", k), 136'(mwdata), 136'(vecs[k].e_mwdata));
            check($sformatf("vec%0d mstrb", k),  136'(mstrb),  136'(vecs[k].e_mstrb));
            check($sformatf("vec%0d irdata", k), 136'(irdata), 136'(vecs[k].e_irdata));
            check($sformatf("vec%0d drdata", k), 136'(drdata), 136'(vecs[k].e_drdata));
            do_cycle($sformatf("vec%0d", k), g);
        end

        // contention with no lock: strict alternation after the first fetch
        apply_reset();
        ireq = 1; dreq = 1;
        run_seq("rr", "-I-R-I-R", 0);

        // locked read then unlocked write back-to-back, fetch waits for both
        apply_reset();
        ireq = 1; dreq = 1; dlock = 1;
        run_seq("amo", "-I-RW-I", 1);

        // lock held forever: guard releases after LOCK_MAX completions
        apply_reset();
        dreq = 1; dlock = 1;
        run_seq("lockmax", "-RRRR-I", 2);

        // randomized masters obeying the hold-until-served rule
        apply_reset();
        i_done = 0; d_done = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!ireq || i_done) begin
                ireq  = ($urandom_range(0, 2) != 0);
                iaddr = $urandom;
            end
            if (!dreq || d_done) begin
                dreq   = ($urandom_range(0, 2) != 0);
                dwe    = 1'($urandom);
                dlock  = ($urandom_range(0, 3) != 0);
                daddr  = $urandom;
                dwdata = $urandom;
                dstrb  = 4'($urandom);
            end
            if ($urandom_range(0, 99) == 0) ireq = 0;
            if ($urandom_range(0, 99) == 0) dreq = 0;
            mready = ($urandom_range(0, 3) != 0);
            mrdata = $urandom;
            rst    = ($urandom_range(0, 199) == 0);
            do_cycle("rand", g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
